// File: rtl/gpca_pkg.sv
// Shared types for the GPCA operand path: operand widths, the issue bundle
// layout and the issue-stage state encoding.
package gpca_pkg;

  localparam int GPCA_A_W = 10;
  localparam int GPCA_B_W = 7;
  localparam int GPCA_P_W = 5;

  // Field order is the FIFO entry layout, MSB first.
  typedef struct packed {
    logic                x;
    logic [GPCA_P_W-1:0] p;
    logic [GPCA_B_W-1:0] b;
    logic [GPCA_B_W-1:0] c;
    logic [GPCA_A_W-1:0] a;
  } gpca_operand_t;

  localparam int GPCA_OPERAND_W = $bits(gpca_operand_t);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    VALID
  } gpca_issue_state_t;

endpackage

// File: rtl/gpca_issue_fifo.sv
// Synchronous operand FIFO with a registered, pop-on-read output port.
// rd_data only changes on an accepted pop and clears to zero on reset.
module gpca_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_MAX);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is left unreset so it maps onto block RAM; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rd_data    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_data    <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gpca_issue.sv
// Operand issue stage ahead of the GPCA array: FIFO, settle timer and
// out_valid handshake. Define GPCA_ISSUE_STATS_EN to enable the counters.
module gpca_issue
  import gpca_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_x,
  input  logic [GPCA_P_W-1:0]   in_p,
  input  logic [GPCA_B_W-1:0]   in_b,
  input  logic [GPCA_B_W-1:0]   in_c,
  input  logic [GPCA_A_W-1:0]   in_a,
  output logic                  op_x,
  output logic [GPCA_P_W-1:0]   op_p,
  output logic [GPCA_B_W-1:0]   op_b,
  output logic [GPCA_B_W-1:0]   op_c,
  output logic [GPCA_A_W-1:0]   op_a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]           issued_cnt,
  output logic [15:0]           stall_cnt
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam gpca_issue_state_t POP_STATE = (SETTLE_CYC == 0) ? VALID : SETTLE;

  gpca_operand_t     push_op;
  gpca_operand_t     head_op;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  gpca_issue_state_t state_reg;
  gpca_issue_state_t state_next;
  logic [3:0]        settle_reg;
  logic [3:0]        settle_next;

  assign push_op  = '{x: in_x, p: in_p, b: in_b, c: in_c, a: in_a};
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;

  // The FIFO read register doubles as the operand register driving the array.
  gpca_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GPCA_OPERAND_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_op),
    .pop       (pop),
    .rd_data   (head_op),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign op_x      = head_op.x;
  assign op_p      = head_op.p;
  assign op_b      = head_op.b;
  assign op_c      = head_op.c;
  assign op_a      = head_op.a;
  assign out_valid = (state_reg == VALID);

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          settle_next = SETTLE_LD;
          state_next  = POP_STATE;
        end
      end
      SETTLE: begin
        settle_next = settle_reg - 4'd1;
        if (settle_reg <= 4'd1) begin
          state_next = VALID;
        end
      end
      VALID: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            settle_next = SETTLE_LD;
            state_next  = POP_STATE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
    end
  end

`ifdef GPCA_ISSUE_STATS_EN
  logic [15:0] issued_reg;
  logic [15:0] stall_reg;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_reg <= '0;
      stall_reg  <= '0;
    end else begin
      if (out_valid && out_ready && (issued_reg != 16'hFFFF)) begin
        issued_reg <= issued_reg + 16'd1;
      end
      if (in_valid && !in_ready && (stall_reg != 16'hFFFF)) begin
        stall_reg <= stall_reg + 16'd1;
      end
    end
  end

  assign issued_cnt = issued_reg;
  assign stall_cnt  = stall_reg;
`else
  assign issued_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule
